// File: rtl/mem_access_ctrl_pkg.sv
// Shared constants and encodings for the memory access controller.
// Holds the NOP control code, the request op classes and the FSM states.
package mem_access_ctrl_pkg;

    localparam logic [1:0] CTL_NOP = 2'd3;

    typedef enum logic [1:0] {
        OP_NOP,
        OP_READ,
        OP_WRITE,
        OP_ILLEGAL
    } op_class_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_BLOCKED
    } state_t;

    function automatic op_class_t classify_op(input logic [1:0] rdctl, input logic [1:0] wrctl);
        op_class_t cls;
        if (rdctl == CTL_NOP && wrctl == CTL_NOP) begin
            cls = OP_NOP;
        end else if (wrctl == CTL_NOP) begin
            cls = OP_READ;
        end else if (rdctl == CTL_NOP) begin
            cls = OP_WRITE;
        end else begin
            cls = OP_ILLEGAL;
        end
        return cls;
    endfunction

endpackage

// File: rtl/mem_req_fifo.sv
// In-order request queue with full/empty flags and a combinational head.
// QDEPTH must be a power of two so the pointers wrap naturally.
module mem_req_fifo #(
    parameter int WIDTH  = 8,
    parameter int QDEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(QDEPTH);

    logic [WIDTH-1:0] mem [QDEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PW+1)'(QDEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Queues legal read/write requests and issues them in order to a memory port,
// tracking address/opcode faults and heads that stay blocked too long.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 1024,
    parameter int QDEPTH    = 4,
    parameter int BLOCK_MAX = 15
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              reqvalid,
    output logic              reqready,
    input  logic [ADDR_W-1:0] reqaddr,
    input  logic [1:0]        reqrdctl,
    input  logic [1:0]        reqwrctl,
    input  logic [DATA_W-1:0] reqwdata,
    input  logic              reqwrcheck,
    input  logic              membusyrd,
    input  logic              membusywr,
    output logic [1:0]        memrdctl,
    output logic [1:0]        memwrctl,
    output logic [ADDR_W-1:0] memaddr,
    output logic [DATA_W-1:0] memwdata,
    output logic              memwrcheck,
    output logic              fault,
    output logic [ADDR_W-1:0] faultaddr,
    output logic [7:0]        faultcount,
    input  logic              faultclr,
    output logic              timeout
);

    localparam int EW    = 2 + 2 + ADDR_W + DATA_W + 1;
    localparam int CNT_W = $clog2(BLOCK_MAX + 1);
    localparam logic [CNT_W-1:0] BMAX = CNT_W'(BLOCK_MAX);

    op_class_t         req_cls;
    logic              accept, oob, bad, push;
    logic [EW-1:0]     fifo_din, fifo_dout;
    logic              full, empty;
    logic [1:0]        head_rd, head_wr;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_wdata;
    logic              head_chk, head_is_read;
    state_t            cur_state, prev_state;
    logic              issue, blocked;
    logic [CNT_W-1:0]  blk_cnt, blk_cnt_next;

    assign req_cls  = classify_op(reqrdctl, reqwrctl);
    assign reqready = !full;
    assign accept   = reqvalid && !full;
    assign oob      = 64'(reqaddr) >= 64'(MEM_DEPTH);
    assign bad      = accept && (req_cls == OP_ILLEGAL || (req_cls != OP_NOP && oob));
    assign push     = accept && !oob && (req_cls == OP_READ || req_cls == OP_WRITE);
    assign fifo_din = {reqrdctl, reqwrctl, reqaddr, reqwdata, reqwrcheck};
    assign {head_rd, head_wr, head_addr, head_wdata, head_chk} = fifo_dout;
    assign head_is_read = (head_wr == CTL_NOP);

    mem_req_fifo #(
        .WIDTH (EW),
        .QDEPTH(QDEPTH)
    ) u_fifo (
        .clk  (clk),
        .rstn (rstn),
        .push (push),
        .pop  (issue),
        .din  (fifo_din),
        .dout (fifo_dout),
        .full (full),
        .empty(empty)
    );

    // prev_state remembers last cycle's state so a blocked run restarts at 1.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) prev_state <= ST_IDLE;
        else       prev_state <= cur_state;
    end

    // Busy is judged in the cycle before the edge that would issue the head.
    always_comb begin
        cur_state = ST_IDLE;
        if (!empty) begin
            if (head_is_read ? membusyrd : membusywr) cur_state = ST_BLOCKED;
            else                                      cur_state = ST_ISSUE;
        end
    end

    always_comb begin
        issue        = (cur_state == ST_ISSUE);
        blocked      = (cur_state == ST_BLOCKED);
        blk_cnt_next = '0;
        if (blocked) begin
            if (prev_state != ST_BLOCKED) blk_cnt_next = CNT_W'(1);
            else if (blk_cnt == BMAX)     blk_cnt_next = blk_cnt;
            else                          blk_cnt_next = blk_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            memrdctl   <= CTL_NOP;
            memwrctl   <= CTL_NOP;
            memaddr    <= '0;
            memwdata   <= '0;
            memwrcheck <= 1'b0;
        end else if (issue) begin
            memrdctl   <= head_is_read ? head_rd : CTL_NOP;
            memwrctl   <= head_is_read ? CTL_NOP : head_wr;
            memaddr    <= head_addr;
            memwdata   <= head_wdata;
            memwrcheck <= head_is_read ? 1'b0 : head_chk;
        end else begin
            memrdctl   <= CTL_NOP;
            memwrctl   <= CTL_NOP;
            memwrcheck <= 1'b0;
        end
    end

    // Timeout fires once per blocked run; a clear cannot hide a same-cycle set.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            blk_cnt <= '0;
            timeout <= 1'b0;
        end else begin
            blk_cnt <= blk_cnt_next;
            if (blocked && blk_cnt_next == BMAX && blk_cnt != BMAX) timeout <= 1'b1;
            else if (faultclr)                                       timeout <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fault      <= 1'b0;
            faultaddr  <= '0;
            faultcount <= '0;
        end else if (bad) begin
            if (!fault || faultclr) begin
                fault      <= 1'b1;
                faultaddr  <= reqaddr;
                faultcount <= 8'd1;
            end else if (faultcount != 8'hFF) begin
                faultcount <= faultcount + 8'd1;
            end
        end else if (faultclr) begin
            fault      <= 1'b0;
            faultaddr  <= '0;
            faultcount <= '0;
        end
    end

endmodule
